// File: rtl/tlb_ctrl.sv
// TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) between CP0 registers and a TLB array.
// Define TLB_RANDOM_EN to give TLBWR a free-running random index; otherwise TLBWR uses the index register.
module tlb_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          op_done,
  input  logic [31:0]   entryhi_in,
  input  logic [31:0]   entrylo0_in,
  input  logic [31:0]   entrylo1_in,
  input  logic [31:0]   index_in,
  output logic [31:0]   entryhi_out,
  output logic [31:0]   entrylo0_out,
  output logic [31:0]   entrylo1_out,
  output logic [31:0]   index_out,
  output logic          entryhi_we,
  output logic          entrylo0_we,
  output logic          entrylo1_we,
  output logic          index_we,
  output logic [18:0]   s_vpn2,
  output logic          s_odd_page,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  output logic [IW-1:0] r_index,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1,
  output logic          w_we,
  output logic [IW-1:0] w_index,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1
);

  typedef enum logic [2:0] {IDLE, SEARCH, READ, WRITE, DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] w_rand_idx;

`ifdef TLB_RANDOM_EN
  logic [IW-1:0] r_random;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               r_random <= IW'(TLBNUM - 1);
    else if (r_random == '0)   r_random <= IW'(TLBNUM - 1);
    else                       r_random <= r_random - IW'(1);
  end

  assign w_rand_idx = r_random;
`else
  assign w_rand_idx = index_in[IW-1:0];
`endif

  // Bits of the CP0 inputs that no TLB field consumes.
  logic w_unused;
  assign w_unused = ^{entryhi_in[12:8], entrylo0_in[31:26], entrylo1_in[31:26], index_in[31:IW]};

  assign s_odd_page = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      op_ready     <= 1'b1;
      op_done      <= 1'b0;
      entryhi_out  <= '0;
      entrylo0_out <= '0;
      entrylo1_out <= '0;
      index_out    <= '0;
      entryhi_we   <= 1'b0;
      entrylo0_we  <= 1'b0;
      entrylo1_we  <= 1'b0;
      index_we     <= 1'b0;
      s_vpn2       <= '0;
      s_asid       <= '0;
      r_index      <= '0;
      w_we         <= 1'b0;
      w_index      <= '0;
      w_vpn2       <= '0;
      w_asid       <= '0;
      w_g          <= 1'b0;
      w_pfn0       <= '0;
      w_c0         <= '0;
      w_d0         <= 1'b0;
      w_v0         <= 1'b0;
      w_pfn1       <= '0;
      w_c1         <= '0;
      w_d1         <= 1'b0;
      w_v1         <= 1'b0;
    end else begin
      // Pulses and port drives default low; the state that owns them re-asserts.
      op_done     <= 1'b0;
      entryhi_we  <= 1'b0;
      entrylo0_we <= 1'b0;
      entrylo1_we <= 1'b0;
      index_we    <= 1'b0;
      w_we        <= 1'b0;
      s_vpn2      <= '0;
      s_asid      <= '0;
      r_index     <= '0;
      case (r_state)
        IDLE: if (op_valid) begin
          op_ready <= 1'b0;
          case (op_code)
            2'b00: begin
              r_state <= SEARCH;
              s_vpn2  <= entryhi_in[31:13];
              s_asid  <= entryhi_in[7:0];
            end
            2'b01: begin
              r_state <= READ;
              r_index <= index_in[IW-1:0];
            end
            default: begin
              r_state <= WRITE;
              w_we    <= 1'b1;
              w_index <= op_code[0] ? w_rand_idx : index_in[IW-1:0];
              w_vpn2  <= entryhi_in[31:13];
              w_asid  <= entryhi_in[7:0];
              w_g     <= entrylo0_in[0] & entrylo1_in[0];
              w_pfn0  <= entrylo0_in[25:6];
              w_c0    <= entrylo0_in[5:3];
              w_d0    <= entrylo0_in[2];
              w_v0    <= entrylo0_in[1];
              w_pfn1  <= entrylo1_in[25:6];
              w_c1    <= entrylo1_in[5:3];
              w_d1    <= entrylo1_in[2];
              w_v1    <= entrylo1_in[1];
            end
          endcase
        end
        SEARCH: begin
          r_state   <= DONE;
          op_done   <= 1'b1;
          index_we  <= 1'b1;
          index_out <= s_found ? {{(32-IW){1'b0}}, s_index} : 32'h8000_0000;
        end
        READ: begin
          r_state      <= DONE;
          op_done      <= 1'b1;
          entryhi_we   <= 1'b1;
          entrylo0_we  <= 1'b1;
          entrylo1_we  <= 1'b1;
          entryhi_out  <= {r_vpn2, 5'b0, r_asid};
          entrylo0_out <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
          entrylo1_out <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
        end
        WRITE: begin
          r_state <= DONE;
          op_done <= 1'b1;
        end
        default: begin
          r_state  <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed testbench for tlb_ctrl with a small behavioural TLB array on the search/read/write ports.
module tb_tlb_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW     = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          op_valid = 1'b0;
  logic [1:0]    op_code = '0;
  logic          op_ready, op_done;
  logic [31:0]   entryhi_in = '0, entrylo0_in = '0, entrylo1_in = '0, index_in = '0;
  logic [31:0]   entryhi_out, entrylo0_out, entrylo1_out, index_out;
  logic          entryhi_we, entrylo0_we, entrylo1_we, index_we;
  logic [18:0]   s_vpn2;
  logic          s_odd_page;
  logic [7:0]    s_asid;
  logic          s_found;
  logic [IW-1:0] s_index;
  logic [IW-1:0] r_index;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic          r_g, r_d0, r_v0, r_d1, r_v1;
  logic [19:0]   r_pfn0, r_pfn1;
  logic [2:0]    r_c0, r_c1;
  logic          w_we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic [19:0]   w_pfn0, w_pfn1;
  logic [2:0]    w_c0, w_c1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done),
    .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in), .index_in(index_in),
    .entryhi_out(entryhi_out), .entrylo0_out(entrylo0_out), .entrylo1_out(entrylo1_out), .index_out(index_out),
    .entryhi_we(entryhi_we), .entrylo0_we(entrylo0_we), .entrylo1_we(entrylo1_we), .index_we(index_we),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .w_we(w_we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1)
  );

  // TLB array: entry 3 maps VPN2 2 / ASID 5, others hold distinct unmatched tags.
  logic [18:0] m_vpn2 [TLBNUM];
  logic [7:0]  m_asid [TLBNUM];
  logic        m_g    [TLBNUM];
  logic [19:0] m_pfn0 [TLBNUM];
  logic [19:0] m_pfn1 [TLBNUM];
  logic [2:0]  m_c0   [TLBNUM];
  logic [2:0]  m_c1   [TLBNUM];
  logic        m_d0   [TLBNUM];
  logic        m_v0   [TLBNUM];
  logic        m_d1   [TLBNUM];
  logic        m_v1   [TLBNUM];
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < TLBNUM; i++) begin
        m_vpn2[i] <= (i == 3) ? 19'h2 : 19'(32'h1000 + i);
        m_asid[i] <= (i == 3) ? 8'h05 : 8'h00;
        m_g[i] <= 1'b0; m_pfn0[i] <= '0; m_pfn1[i] <= '0; m_c0[i] <= '0; m_c1[i] <= '0;
        m_d0[i] <= 1'b0; m_v0[i] <= 1'b0; m_d1[i] <= 1'b0; m_v1[i] <= 1'b0;
      end
    end else if (w_we) begin
      m_vpn2[w_index] <= w_vpn2; m_asid[w_index] <= w_asid; m_g[w_index] <= w_g;
      m_pfn0[w_index] <= w_pfn0; m_c0[w_index] <= w_c0; m_d0[w_index] <= w_d0; m_v0[w_index] <= w_v0;
      m_pfn1[w_index] <= w_pfn1; m_c1[w_index] <= w_c1; m_d1[w_index] <= w_d1; m_v1[w_index] <= w_v1;
    end
  end

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (!s_found && m_vpn2[i] == s_vpn2 && (m_g[i] || m_asid[i] == s_asid)) begin
        s_found = 1'b1;
        s_index = IW'(i);
      end
    end
  end

  assign r_vpn2 = m_vpn2[r_index];
  assign r_asid = m_asid[r_index];
  assign r_g    = m_g[r_index];
  assign r_pfn0 = m_pfn0[r_index];
  assign r_c0   = m_c0[r_index];
  assign r_d0   = m_d0[r_index];
  assign r_v0   = m_v0[r_index];
  assign r_pfn1 = m_pfn1[r_index];
  assign r_c1   = m_c1[r_index];
  assign r_d1   = m_d1[r_index];
  assign r_v1   = m_v1[r_index];

  // Present one request for one cycle; returns at the negedge of the first post-accept cycle.
  task automatic start_op(input logic [1:0] code, input logic [31:0] eh, lo0, lo1, idx);
    @(negedge clk);
    op_valid = 1'b1; op_code = code;
    entryhi_in = eh; entrylo0_in = lo0; entrylo1_in = lo1; index_in = idx;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; preload = 1'b1;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    tot_cnt++; if (op_ready !== 1'b1) $display("FAIL rst_op_ready got %b exp 1", op_ready); else pass_cnt++;
    tot_cnt++; if (op_done !== 1'b0) $display("FAIL rst_op_done got %b exp 0", op_done); else pass_cnt++;
    tot_cnt++; if (w_we !== 1'b0) $display("FAIL rst_w_we got %b exp 0", w_we); else pass_cnt++;
    tot_cnt++; if ({entryhi_we, entrylo0_we, entrylo1_we, index_we} !== 4'b0)
      $display("FAIL rst_cp0_we got %b exp 0000", {entryhi_we, entrylo0_we, entrylo1_we, index_we}); else pass_cnt++;
    tot_cnt++; if ({entryhi_out, entrylo0_out, entrylo1_out, index_out} !== 128'h0)
      $display("FAIL rst_cp0_out got %h exp 0", {entryhi_out, entrylo0_out, entrylo1_out, index_out}); else pass_cnt++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tlbp_hit;
    start_op(2'b00, 32'h0000_4005, '0, '0, '0);
    tot_cnt++; if (op_ready !== 1'b0) $display("FAIL tlbp_busy got %b exp 0", op_ready); else pass_cnt++;
    tot_cnt++; if (s_vpn2 !== 19'h2 || s_asid !== 8'h05 || s_odd_page !== 1'b0)
      $display("FAIL tlbp_sport got %h/%h/%b exp 2/05/0", s_vpn2, s_asid, s_odd_page); else pass_cnt++;
    tot_cnt++; if (op_done !== 1'b0) $display("FAIL tlbp_early_done got %b exp 0", op_done); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (op_done !== 1'b1) $display("FAIL tlbp_done got %b exp 1", op_done); else pass_cnt++;
    tot_cnt++; if (index_out !== 32'h0000_0003) $display("FAIL tlbp_index got %h exp 00000003", index_out); else pass_cnt++;
    tot_cnt++; if ({entryhi_we, entrylo0_we, entrylo1_we, index_we} !== 4'b0001)
      $display("FAIL tlbp_we got %b exp 0001", {entryhi_we, entrylo0_we, entrylo1_we, index_we}); else pass_cnt++;
    tot_cnt++; if (s_vpn2 !== 19'h0) $display("FAIL tlbp_sport_idle got %h exp 0", s_vpn2); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (op_ready !== 1'b1 || op_done !== 1'b0)
      $display("FAIL tlbp_idle got rdy %b done %b exp 1 0", op_ready, op_done); else pass_cnt++;
  endtask

  task automatic test_tlbp_miss;
    start_op(2'b00, 32'h0000_8009, '0, '0, '0);
    @(negedge clk);
    tot_cnt++; if (index_out !== 32'h8000_0000) $display("FAIL tlbp_miss got %h exp 80000000", index_out); else pass_cnt++;
    tot_cnt++; if (index_we !== 1'b1) $display("FAIL tlbp_miss_we got %b exp 1", index_we); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_tlbwi;
    start_op(2'b10, 32'h0000_6007, 32'h0000_0047, 32'h0000_0086, 32'd5);
    tot_cnt++; if (w_we !== 1'b1 || w_index !== 4'd5)
      $display("FAIL tlbwi_we_idx got %b/%0d exp 1/5", w_we, w_index); else pass_cnt++;
    tot_cnt++; if (w_pfn0 !== 20'h1 || w_pfn1 !== 20'h2 || w_g !== 1'b0)
      $display("FAIL tlbwi_fields got %h/%h/%b exp 1/2/0", w_pfn0, w_pfn1, w_g); else pass_cnt++;
    tot_cnt++; if (w_vpn2 !== 19'h3 || w_asid !== 8'h07 || {w_d0, w_v0, w_d1, w_v1} !== 4'b1111)
      $display("FAIL tlbwi_hi got %h/%h/%b exp 3/07/1111", w_vpn2, w_asid, {w_d0, w_v0, w_d1, w_v1}); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (w_we !== 1'b0 || op_done !== 1'b1)
      $display("FAIL tlbwi_done got we %b done %b exp 0 1", w_we, op_done); else pass_cnt++;
    tot_cnt++; if ({entryhi_we, entrylo0_we, entrylo1_we, index_we} !== 4'b0)
      $display("FAIL tlbwi_cp0_we got %b exp 0000", {entryhi_we, entrylo0_we, entrylo1_we, index_we}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_tlbr;
    start_op(2'b01, '0, '0, '0, 32'd5);
    tot_cnt++; if (r_index !== 4'd5) $display("FAIL tlbr_rindex got %0d exp 5", r_index); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (entryhi_out !== 32'h0000_6007) $display("FAIL tlbr_hi got %h exp 00006007", entryhi_out); else pass_cnt++;
    tot_cnt++; if (entrylo0_out !== 32'h0000_0046) $display("FAIL tlbr_lo0 got %h exp 00000046", entrylo0_out); else pass_cnt++;
    tot_cnt++; if (entrylo1_out !== 32'h0000_0086) $display("FAIL tlbr_lo1 got %h exp 00000086", entrylo1_out); else pass_cnt++;
    tot_cnt++; if ({op_done, entryhi_we, entrylo0_we, entrylo1_we, index_we} !== 5'b11110)
      $display("FAIL tlbr_we got %b exp 11110", {op_done, entryhi_we, entrylo0_we, entrylo1_we, index_we}); else pass_cnt++;
    tot_cnt++; if (r_index !== 4'd0) $display("FAIL tlbr_rport_idle got %0d exp 0", r_index); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_truncate;
    start_op(2'b10, 32'h0000_A00B, '0, '0, 32'h15);
    tot_cnt++; if (w_index !== 4'd5) $display("FAIL trunc_idx got %0d exp 5", w_index); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    start_op(2'b00, 32'h0000_4005, '0, '0, '0);
    @(negedge clk);
    tot_cnt++; if (op_done !== 1'b1) $display("FAIL b2b_first_done got %b exp 1", op_done); else pass_cnt++;
    op_valid = 1'b1; op_code = 2'b00; entryhi_in = 32'h0000_8009;
    @(negedge clk);
    tot_cnt++; if (op_ready !== 1'b1 || op_done !== 1'b0)
      $display("FAIL b2b_idle got rdy %b done %b exp 1 0", op_ready, op_done); else pass_cnt++;
    @(negedge clk);
    op_valid = 1'b0;
    tot_cnt++; if (s_vpn2 !== 19'h4) $display("FAIL b2b_search got %h exp 4", s_vpn2); else pass_cnt++;
    @(negedge clk);
    tot_cnt++; if (op_done !== 1'b1 || index_out !== 32'h8000_0000)
      $display("FAIL b2b_second got done %b idx %h exp 1 80000000", op_done, index_out); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_tlbwr;
    logic [IW-1:0] exp_idx;
`ifdef TLB_RANDOM_EN
    exp_idx = 4'd12;
`else
    exp_idx = 4'd7;
`endif
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11; entryhi_in = 32'h0000_C00D; index_in = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    tot_cnt++; if (w_we !== 1'b1 || w_index !== exp_idx)
      $display("FAIL tlbwr_idx got we %b idx %0d exp 1 %0d", w_we, w_index, exp_idx); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [18:0] saved;
    logic        seen_done;
    saved = m_vpn2[9];
    seen_done = 1'b0;
    start_op(2'b10, 32'h0000_E00F, 32'h0000_0047, 32'h0000_0086, 32'd9);
    tot_cnt++; if (w_we !== 1'b1) $display("FAIL abort_in_write got %b exp 1", w_we); else pass_cnt++;
    resetn = 1'b0;
    #1;
    tot_cnt++; if (w_we !== 1'b0 || op_ready !== 1'b1)
      $display("FAIL abort_async got we %b rdy %b exp 0 1", w_we, op_ready); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (op_done || entryhi_we || entrylo0_we || entrylo1_we || index_we) seen_done = 1'b1;
    end
    tot_cnt++; if (seen_done !== 1'b0) $display("FAIL abort_no_done got %b exp 0", seen_done); else pass_cnt++;
    tot_cnt++; if (m_vpn2[9] !== saved) $display("FAIL abort_no_write got %h exp %h", m_vpn2[9], saved); else pass_cnt++;
    tot_cnt++; if (op_ready !== 1'b1) $display("FAIL abort_ready got %b exp 1", op_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tlbp_hit();
    test_tlbp_miss();
    test_tlbwi();
    test_tlbr();
    test_truncate();
    test_back_to_back();
    test_tlbwr();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
